// File: rtl/mux4_1.sv
// rtl/mux4_1.sv - 4-to-1 mux built from a two-level 2-to-1 tree, with a registered copy of the output.
// OUT is purely combinational; OUT_Q is the only state and resets asynchronously to RESET_VAL.

module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

module mux4_1 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] INPUT,
  input  logic [1:0] s,
  output logic       OUT,
  output logic       OUT_Q
);

  logic ma_y;
  logic mb_y;

  // Level 1 pairs channels by s[0]; level 2 picks the pair with s[1].
  mux2_1 mA (
    .a   (INPUT[0]),
    .b   (INPUT[1]),
    .sel (s[0]),
    .y   (ma_y)
  );

  mux2_1 mB (
    .a   (INPUT[2]),
    .b   (INPUT[3]),
    .sel (s[0]),
    .y   (mb_y)
  );

  mux2_1 mC (
    .a   (ma_y),
    .b   (mb_y),
    .sel (s[1]),
    .y   (OUT)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      OUT_Q <= RESET_VAL;
    end else begin
      OUT_Q <= OUT;
    end
  end

endmodule

// File: tb/tb_mux4_1.sv
// tb/tb_mux4_1.sv - directed-vector bench for mux4_1: exhaustive combinational sweep, latency and async reset.

module tb_mux4_1;

  logic       clk;
  logic       clk_en;
  logic       reset_n;
  logic [3:0] INPUT;
  logic [1:0] s;
  logic       OUT;
  logic       OUT_Q;

  int n_cmp;
  int n_err;

  mux4_1 #(.RESET_VAL(1'b0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .INPUT   (INPUT),
    .s       (s),
    .OUT     (OUT),
    .OUT_Q   (OUT_Q)
  );

  // Clock only toggles once enabled, so the combinational sweep runs with no edges.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register-path vectors: {INPUT, s, expected OUT_Q after one edge}
  logic [3:0] rv_in  [6] = '{4'b0001, 4'b0001, 4'b0110, 4'b0110, 4'b1011, 4'b1011};
  logic [1:0] rv_s   [6] = '{2'd0,    2'd1,    2'd2,    2'd0,    2'd3,    2'd2};
  logic       rv_exp [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    clk_en  = 1'b0;
    reset_n = 1'b0;
    INPUT   = 4'd0;
    s       = 2'd0;
    #1;
    check_bit("reset_out_q", OUT_Q, 1'b0);
    check_bit("reset_out", OUT, 1'b0);

    // Exhaustive sweep with reset held and no clock: OUT must still follow INPUT[s].
    for (int si = 0; si < 4; si++) begin
      for (int v = 0; v < 16; v++) begin
        logic [3:0] vv;
        vv    = 4'(v);
        INPUT = vv;
        s     = 2'(si);
        #1;
        check_bit($sformatf("sweep_s%0d_in%0h", si, v), OUT, vv[si]);
        #1;
      end
    end
    check_bit("sweep_out_q_held", OUT_Q, 1'b0);

    INPUT = 4'b1010; s = 2'd0; #1; check_bit("spot_1010_s0", OUT, 1'b0);
    INPUT = 4'b1010; s = 2'd1; #1; check_bit("spot_1010_s1", OUT, 1'b1);
    INPUT = 4'b1010; s = 2'd3; #1; check_bit("spot_1010_s3", OUT, 1'b1);
    INPUT = 4'b0100; s = 2'd2; #1; check_bit("spot_0100_s2", OUT, 1'b1);

    clk_en = 1'b1;
    #2;
    reset_n = 1'b1;

    INPUT = 4'b1000; s = 2'd3;
    tick();
    check_bit("lat_first_edge", OUT_Q, 1'b1);
    s = 2'd0;
    #1;
    check_bit("lat_comb_now", OUT, 1'b0);
    check_bit("lat_q_holds", OUT_Q, 1'b1);
    tick();
    check_bit("lat_second_edge", OUT_Q, 1'b0);

    #2;
    INPUT = 4'b0100; s = 2'd2;
    tick();
    check_bit("simul_change", OUT_Q, 1'b1);

    for (int k = 0; k < 6; k++) begin
      INPUT = rv_in[k];
      s     = rv_s[k];
      tick();
      check_bit($sformatf("reg_vec%0d", k), OUT_Q, rv_exp[k]);
    end

    INPUT = 4'b0100; s = 2'd2;
    tick();
    check_bit("pre_async_q", OUT_Q, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("async_reset_q", OUT_Q, 1'b0);
    check_bit("async_reset_out", OUT, 1'b1);

    INPUT = 4'hF; s = 2'd1;
    for (int e = 0; e < 3; e++) begin
      tick();
      check_bit($sformatf("hold_q_e%0d", e), OUT_Q, 1'b0);
      check_bit($sformatf("hold_out_e%0d", e), OUT, 1'b1);
    end
    #2;
    reset_n = 1'b1;
    #1;
    check_bit("release_no_edge", OUT_Q, 1'b0);
    tick();
    check_bit("release_first_edge", OUT_Q, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
